// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states, SPI mode encodings and parameter checks for the SPI master
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_HOLD,
      ST_DONE
   } spi_state_t;

   // SPI modes encoded as {cpol, cpha}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   localparam int MIN_DATA_W = 4;
   localparam int MAX_DATA_W = 32;

   function automatic bit data_w_ok(input int w);
      return (w >= MIN_DATA_W) && (w <= MAX_DATA_W);
   endfunction

   // Width of the chip-select index, at least one bit
   function automatic int cs_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: SCK half-period divider, edge counter and leading/trailing edge strobes
module spi_sck_gen #(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_run,
   input  logic             i_idle,
   input  logic             i_cpol,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_sck,
   output logic             o_tick,
   output logic             o_lead_pulse,
   output logic             o_trail_pulse,
   output logic             o_last_edge
);

   localparam int            EW    = $clog2(2 * DATA_W + 1);
   localparam logic [EW-1:0] EDGES = EW'(2 * DATA_W);

   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_cnt;
   logic [EW-1:0]    r_edge;
   logic             r_prime;
   logic             r_sck;
   logic             w_tick;
   logic             w_edge;

   // A tick is a half-period expiry; it only moves SCK while edges remain, the final tick closes the hold phase
   assign w_tick        = i_run && !r_prime && (r_cnt == '0);
   assign w_edge        = w_tick && (r_edge != EDGES);
   assign o_tick        = w_tick;
   assign o_lead_pulse  = w_edge && !r_edge[0];
   assign o_trail_pulse = w_edge && r_edge[0];
   assign o_last_edge   = w_edge && (r_edge == EDGES - EW'(1));
   assign o_sck         = r_sck;

   // Divider and edge counter; the prime cycle delays the first half-period by one clock after start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div   <= '0;
         r_cnt   <= '0;
         r_edge  <= '0;
         r_prime <= 1'b0;
         r_sck   <= 1'b0;
      end else if (i_start) begin
         r_div   <= i_div;
         r_cnt   <= i_div;
         r_edge  <= '0;
         r_prime <= 1'b1;
         r_sck   <= i_cpol;
      end else if (i_run) begin
         if (r_prime) r_prime <= 1'b0;
         else if (r_cnt != '0) r_cnt <= r_cnt - DIV_W'(1);
         else begin
            r_cnt <= r_div;
            if (w_edge) begin
               r_edge <= r_edge + EW'(1);
               r_sck  <= ~r_sck;
            end
         end
      end else if (i_idle) begin
         r_sck <= i_cpol;
      end
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: CPU-side SPI master with level request handshake, wait stall, four modes and chip-select decode
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 2,
   parameter int DIV_W  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enviar_dato,
   input  logic                        recibir_dato,
   input  logic [DATA_W-1:0]           din,
   output logic [DATA_W-1:0]           dout,
   output logic                        wait_n,
   output logic                        busy,
   input  logic [cs_width(NUM_CS)-1:0] cs_sel,
   input  logic                        cpol,
   input  logic                        cpha,
   input  logic [DIV_W-1:0]            clk_div,
   output logic                        spi_clk,
   output logic                        spi_di,
   input  logic                        spi_do,
   output logic [NUM_CS-1:0]           spi_cs_n
);

   localparam int CS_W = cs_width(NUM_CS);

   if (!data_w_ok(DATA_W)) begin : g_bad_data_w
      $error("spi_master_ctrl: DATA_W must be within 4..32");
   end
   if (NUM_CS < 1) begin : g_bad_num_cs
      $error("spi_master_ctrl: NUM_CS must be at least 1");
   end

   spi_state_t        r_state;
   logic [DATA_W-1:0] r_tx;
   logic [DATA_W-1:0] r_rx;
   logic [DATA_W-1:0] r_dout;
   logic [NUM_CS-1:0] r_cs_n;
   logic              r_wait_n;
   logic              r_busy;
   logic              r_cpha;
   logic              r_is_wr;
   logic              r_fill;
   logic              r_first;
   logic              w_start;
   logic              w_run;
   logic              w_idle;
   logic              w_req_low;
   logic              w_tick;
   logic              w_lead;
   logic              w_trail;
   logic              w_last;
   logic [NUM_CS-1:0] w_cs_dec;

   // Write has priority when both requests arrive together
   assign w_start   = (r_state == ST_IDLE) && (enviar_dato || recibir_dato);
   assign w_run     = (r_state == ST_SHIFT) || (r_state == ST_HOLD);
   assign w_idle    = (r_state == ST_IDLE);
   assign w_req_low = r_is_wr ? !enviar_dato : !recibir_dato;

   // One-hot active-low select; an out-of-range index selects nothing
   always_comb begin
      w_cs_dec = '1;
      for (int i = 0; i < NUM_CS; i++) w_cs_dec[i] = (cs_sel != CS_W'(i));
   end

   spi_sck_gen #(
      .DATA_W(DATA_W),
      .DIV_W (DIV_W)
   ) u_sck (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (w_start),
      .i_run        (w_run),
      .i_idle       (w_idle),
      .i_cpol       (cpol),
      .i_div        (clk_div),
      .o_sck        (spi_clk),
      .o_tick       (w_tick),
      .o_lead_pulse (w_lead),
      .o_trail_pulse(w_trail),
      .o_last_edge  (w_last)
   );

   // Transfer FSM with shift registers; CPHA picks which SCK edge samples and which shifts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_tx     <= '1;
         r_rx     <= '0;
         r_dout   <= '0;
         r_cs_n   <= '1;
         r_wait_n <= 1'b1;
         r_busy   <= 1'b0;
         r_cpha   <= 1'b0;
         r_is_wr  <= 1'b0;
         r_fill   <= 1'b1;
         r_first  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_is_wr  <= enviar_dato;
                  r_tx     <= enviar_dato ? din : '1;
                  r_fill   <= !enviar_dato;
                  r_cpha   <= cpha;
                  r_cs_n   <= w_cs_dec;
                  r_rx     <= '0;
                  r_first  <= 1'b1;
                  r_wait_n <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (w_lead) begin
                  r_first <= 1'b0;
                  if (!r_cpha) r_rx <= {r_rx[DATA_W-2:0], spi_do};
                  else if (!r_first) r_tx <= {r_tx[DATA_W-2:0], r_fill};
               end
               if (w_trail) begin
                  if (r_cpha) r_rx <= {r_rx[DATA_W-2:0], spi_do};
                  else r_tx <= {r_tx[DATA_W-2:0], r_fill};
               end
               if (w_last) r_state <= ST_HOLD;
            end
            ST_HOLD: begin
               if (w_tick) begin
                  r_cs_n   <= '1;
                  r_dout   <= r_rx;
                  r_wait_n <= 1'b1;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (w_req_low) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign dout     = r_dout;
   assign wait_n   = r_wait_n;
   assign busy     = r_busy;
   assign spi_cs_n = r_cs_n;
   assign spi_di   = r_tx[DATA_W-1];

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Parametrised SPI master for the CPU-side peripheral bus. It is the next-generation serial port: configurable word width, programmable SCK divider, all four SPI modes (CPOL/CPHA) and multiple chip selects. It keeps the CPU handshake of the existing port (level-held request strobes, `wait_n` stall, full-duplex capture on writes, MOSI forced high on reads). It sits between the CPU I/O decode and the external SD/flash devices.

## Interface
- `DATA_W`, 8: bits per transfer, 4..32.
- `NUM_CS`, 2: number of chip-select outputs, ≥1.
- `DIV_W`, 4: width of the divider setting.
- `clk` in 1: system clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enviar_dato` in 1: write request, level, held until `wait_n` rises and then dropped.
- `recibir_dato` in 1: read request, same rules.
- `din` in DATA_W: write data, sampled at start.
- `dout` out DATA_W: last received word.
- `wait_n` out 1: 0 while a transfer is in progress (CPU stall).
- `busy` out 1: 1 from start until return to IDLE.
- `cs_sel` in max(1,$clog2(NUM_CS)): target device, sampled at start.
- `cpol`, `cpha` in 1 each: SPI mode, sampled at start.
- `clk_div` in DIV_W: D; SCK half-period = D+1 clk cycles, sampled at start.
- `spi_clk` out 1: SCK.
- `spi_di` out 1: MOSI, MSB first.
- `spi_do` in 1: MISO.
- `spi_cs_n` out NUM_CS: active-low selects.

## Operation
- States: IDLE, SHIFT, HOLD, DONE.
- IDLE, request seen at edge T:
  - Latch `din` for a write, or all-ones for a read. Latch `cs_sel`, `cpol`, `cpha` and D.
  - Clear the RX register. Go to SHIFT. `wait_n`←0, `busy`←1.
  - Select line `cs_sel` is driven low.
  - If `cs_sel` ≥ NUM_CS, no line is selected but the transfer still runs.
- Both requests in the same cycle: the write wins, the read is ignored.
- SHIFT:
  - Half-period counter reloads D. Each expiry toggles `spi_clk`, giving 2·DATA_W edges.
  - Odd-numbered edges are leading edges, even-numbered edges are trailing edges.
  - CPHA=0: sample `spi_do` into the RX LSB on leading edges. Shift TX left on trailing edges.
  - CPHA=1: shift TX left on leading edges except the first. Sample on trailing edges.
  - `spi_di` = TX MSB at all times. Vacated bits fill with 0 on writes and 1 on reads.
- HOLD: one half-period with `spi_clk`=CPOL. At its end:
  - `spi_cs_n` goes all-high.
  - `dout`←RX.
  - `wait_n`←1.
  - Go to DONE.
- DONE: stay until the originating request is low, then go to IDLE with `busy`←0. A held request never restarts a transfer.
- A write captures MISO, so `dout` is valid after both writes and reads.
- In IDLE, `spi_clk` follows the `cpol` input, registered with one cycle of delay.
- Config inputs are ignored outside IDLE.

## Timing
- Reset values:
  - state IDLE
  - `spi_clk`=0, `spi_di`=1, `spi_cs_n`=all 1
  - `dout`=0, `wait_n`=1, `busy`=0
- Reset takes effect immediately, including mid-transfer: select lines release at once and the partial word is discarded.
- Request sampled at edge T. `spi_cs_n`, `wait_n`=0 and the first MOSI bit are visible after T+1.
- Edge k (1..2·DATA_W) of `spi_clk` occurs after clk edge T+1+k·(D+1).
- `wait_n`=1, `dout` valid and CS released occur after T+1+(2·DATA_W+1)·(D+1).
  - Example, DATA_W=8, D=0: T+18.
- Sampling uses the registered `spi_do` value at the edge cycle. Devices must meet the half-period.
- D=0 is legal: SCK = clk/2.
- Divider counter width is DIV_W. The bit counter width is $clog2(2·DATA_W+1).

## Structure
- Package `spi_pkg` holds:
  - the state enum
  - mode constants MODE0..MODE3 as {cpol,cpha}
  - the `DATA_W` range checks
- Sub-module `spi_sck_gen` holds:
  - the divider counter
  - the edge counter
  - the `spi_clk` register
  - its outputs: `lead_pulse`, `trail_pulse`, `last_edge`
- The top level holds the FSM, the shift registers and chip-select decode.

## Test plan
- Mode 0, D=0, write 0xA5 with `spi_do` looped from `spi_di` → MOSI bits 1,0,1,0,0,1,0,1 on leading edges, `dout`=0xA5, `wait_n` high at T+18, one CS low throughout.
- Read in mode 3, D=3, with the slave model returning 0x3C → MOSI constantly 1, `spi_clk` idles 1, `dout`=0x3C, `wait_n` high at T+1+17·4.
- Each mode, write 0x81 to a mode-matched slave model → the slave receives 0x81 in all four modes. CPHA=1 samples on the trailing edge.
- `enviar_dato` and `recibir_dato` both high in the same cycle, `din`=0x5A → write performed, slave sees 0x5A. Holding the request 10 cycles past `wait_n` starts no second transfer. A new request after it drops does start one.
- `cs_sel`=1 with NUM_CS=2, then `cs_sel`=3 with NUM_CS=3 → in the first case only `spi_cs_n[1]` goes low. In the second, no CS goes low but `wait_n` timing is unchanged.
- Assert `rst_n` low at edge 7 of a transfer → immediately `spi_cs_n` all-high, `wait_n`=1, `busy`=0, `dout`=0. The next request completes normally.
